// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : RV32I/RV64I opcode constants and immediate format encodings.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM_32 = 7'h1B;
  localparam logic [6:0] LOAD      = 7'h03;
  localparam logic [6:0] JALR      = 7'h67;
  localparam logic [6:0] STORE     = 7'h23;
  localparam logic [6:0] BRANCH    = 7'h63;
  localparam logic [6:0] JAL       = 7'h6F;
  localparam logic [6:0] LUI       = 7'h37;
  localparam logic [6:0] AUIPC     = 7'h17;
  localparam logic [6:0] OP        = 7'h33;
  localparam logic [6:0] OP_32     = 7'h3B;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_if
// Purpose  : Fetch-side and execute-side handshake bundle of imm_gen_pipe.
// Revision : 1.0
// ============================================================================
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic [XLEN-1:0] target;
  logic            illegal;

  modport slave (
    input  in_valid, instruction, pc, out_ready,
    output in_ready, out_valid, imm, fmt, target, illegal
  );

  modport master (
    output in_valid, instruction, pc, out_ready,
    input  in_ready, out_valid, imm, fmt, target, illegal
  );
endinterface
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode
// Purpose  : Combinational immediate/format/PC-relative target decoder.
// Revision : 1.0
// ============================================================================
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [31:0] imm32;
  fmt_e        fmt;
  logic        use_target;

  assign opcode   = instruction_i[6:0];
  assign funct3   = instruction_i[14:12];
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  // Every format fits in 32 bits; shift amounts have bit 31 clear, so one
  // final sign extension to XLEN serves all formats.
  always_comb begin
    imm32      = '0;
    fmt        = FMT_NONE;
    use_target = 1'b0;
    illegal_o  = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (is_shift) begin
          fmt   = FMT_SH;
          imm32 = 32'(instruction_i[20 +: SHAMT_W]);
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
        end
      end
      OP_IMM_32: begin
        if (is_shift) begin
          fmt   = FMT_SH;
          imm32 = 32'(instruction_i[24:20]);
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
        end
      end
      LOAD, JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      end
      BRANCH: begin
        fmt        = FMT_B;
        use_target = 1'b1;
        imm32      = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                      instruction_i[30:25], instruction_i[11:8], 1'b0};
      end
      JAL: begin
        fmt        = FMT_J;
        use_target = 1'b1;
        imm32      = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                      instruction_i[20], instruction_i[30:21], 1'b0};
      end
      LUI: begin
        fmt   = FMT_U;
        imm32 = {instruction_i[31:12], 12'b0};
      end
      AUIPC: begin
        fmt        = FMT_U;
        use_target = 1'b1;
        imm32      = {instruction_i[31:12], 12'b0};
      end
      OP, OP_32: begin
        fmt = FMT_R;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  assign imm_o    = XLEN'($signed(imm32));
  assign fmt_o    = fmt;
  assign target_o = use_target ? (pc_i + imm_o) : '0;

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered immediate generator behind a 2-entry skid buffer.
// Revision : 1.0
// ============================================================================
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{imm: '0, fmt: FMT_NONE, target: '0, illegal: 1'b0};

  entry_t dec;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   pop;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instruction_i (bus.instruction),
    .pc_i          (bus.pc),
    .imm_o         (dec.imm),
    .fmt_o         (dec.fmt),
    .target_o      (dec.target),
    .illegal_o     (dec.illegal)
  );

  // in_ready comes straight from the skid flag so it never sees out_ready.
  assign bus.in_ready = !skid_valid_q;
  assign accept       = bus.in_valid && !skid_valid_q;
  assign pop          = main_valid_q && bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= RESET_ENTRY;
      skid_q       <= RESET_ENTRY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.out_valid = main_valid_q;
  assign bus.imm       = main_q.imm;
  assign bus.fmt       = main_q.fmt;
  assign bus.target    = main_q.target;
  assign bus.illegal   = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep.
// Revision : 1.0
// ============================================================================
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instruction;
  logic [63:0] pc;

  vec_t vecs[14];
  int   q32[$];
  int   q64[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

  assign b32.in_valid    = in_valid;
  assign b32.instruction = instruction;
  assign b32.pc          = pc[31:0];
  assign b32.out_ready   = out_ready;
  assign b64.in_valid    = in_valid;
  assign b64.instruction = instruction;
  assign b64.pc          = pc;
  assign b64.out_ready   = out_ready;

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(b64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_out(input int w, input int idx, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic [63:0] tgt, input logic ill);
    logic [63:0] e_imm, e_tgt;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL out%0d unexpected: imm=%h fmt=%0d tgt=%h ill=%b", w, imm, fmt, tgt, ill);
      return;
    end
    e_imm = (w == 32) ? {32'h0, vecs[idx].imm32} : vecs[idx].imm64;
    e_tgt = (w == 32) ? {32'h0, vecs[idx].tgt32} : vecs[idx].tgt64;
    if (imm !== e_imm || fmt !== vecs[idx].fmt || tgt !== e_tgt || ill !== vecs[idx].ill) begin
      errors++;
      $display("FAIL out%0d vec%0d: got imm=%h fmt=%0d tgt=%h ill=%b, expected imm=%h fmt=%0d tgt=%h ill=%b",
               w, idx, imm, fmt, tgt, ill, e_imm, vecs[idx].fmt, e_tgt, vecs[idx].ill);
    end
  endtask

  // Monitors: pop on every handshake and check that stalled outputs hold.
  logic        st32 = 1'b0, st64 = 1'b0;
  logic [67:0]  sv32;
  logic [131:0] sv64;

  always @(negedge clk) begin
    if (!reset) begin
      if (st32 && b32.out_valid)
        chk("hold32", 64'({b32.imm, b32.fmt, b32.target, b32.illegal} != sv32), 64'd0);
      if (b32.out_valid && b32.out_ready)
        cmp_out(32, (q32.size() > 0) ? q32.pop_front() : -1,
                {32'h0, b32.imm}, b32.fmt, {32'h0, b32.target}, b32.illegal);
      st32 = b32.out_valid && !b32.out_ready;
      sv32 = {b32.imm, b32.fmt, b32.target, b32.illegal};
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (st64 && b64.out_valid)
        chk("hold64", 64'({b64.imm, b64.fmt, b64.target, b64.illegal} != sv64), 64'd0);
      if (b64.out_valid && b64.out_ready)
        cmp_out(64, (q64.size() > 0) ? q64.pop_front() : -1,
                b64.imm, b64.fmt, b64.target, b64.illegal);
      st64 = b64.out_valid && !b64.out_ready;
      sv64 = {b64.imm, b64.fmt, b64.target, b64.illegal};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx);
    logic acc;
    in_valid    = 1'b1;
    instruction = vecs[idx].inst;
    pc          = vecs[idx].pc;
    for (int n = 0; n < 50; n++) begin
      acc = b32.in_ready;
      tick();
      if (acc) begin
        q32.push_back(idx);
        q64.push_back(idx);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    errors++;
    checks++;
    $display("FAIL send vec%0d: in_ready stayed 0, expected acceptance within 50 cycles", idx);
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (q32.size() == 0 && q64.size() == 0) return;
      tick();
    end
    errors++;
    checks++;
    $display("FAIL drain: %0d/%0d entries outstanding, expected 0", q32.size(), q64.size());
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ov32"}, 64'(b32.out_valid), 64'd0);
    chk({name, "_ov64"}, 64'(b64.out_valid), 64'd0);
    chk({name, "_ir32"}, 64'(b32.in_ready), 64'd1);
    chk({name, "_ir64"}, 64'(b64.in_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs();
    chk_idle("rst");
    chk("rst_imm32", 64'(b32.imm), 64'd0);
    chk("rst_imm64", b64.imm, 64'd0);
    chk("rst_fmt32", 64'(b32.fmt), 64'd7);
    chk("rst_fmt64", 64'(b64.fmt), 64'd7);
    chk("rst_tgt32", 64'(b32.target), 64'd0);
    chk("rst_tgt64", b64.target, 64'd0);
    chk("rst_ill32", 64'(b32.illegal), 64'd0);
    chk("rst_ill64", 64'(b64.illegal), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            inst           pc              imm32          tgt32          imm64                   tgt64                   fmt   ill
    vecs[0]  = '{32'hFFF00093, 64'h0,         32'hFFFFFFFF, 32'h0,         64'hFFFFFFFFFFFFFFFF, 64'h0,                3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 64'h100,       32'hFFFFFFFC, 32'h000000FC,  64'hFFFFFFFFFFFFFFFC, 64'hFC,               3'd3, 1'b0};
    vecs[2]  = '{32'h0080006F, 64'h200,       32'h8,        32'h208,       64'h8,                64'h208,              3'd5, 1'b0};
    vecs[3]  = '{32'h800002B7, 64'h300,       32'h80000000, 32'h0,         64'hFFFFFFFF80000000, 64'h0,                3'd4, 1'b0};
    vecs[4]  = '{32'h03F09093, 64'h304,       32'h1F,       32'h0,         64'h3F,               64'h0,                3'd6, 1'b0};
    vecs[5]  = '{32'h0000007F, 64'h308,       32'h0,        32'h0,         64'h0,                64'h0,                3'd7, 1'b1};
    vecs[6]  = '{32'h00001117, 64'h1000,      32'h1000,     32'h2000,      64'h1000,             64'h2000,             3'd4, 1'b0};
    vecs[7]  = '{32'hFFFFF097, 64'h1000,      32'hFFFFF000, 32'h0,         64'hFFFFFFFFFFFFF000, 64'h0,                3'd4, 1'b0};
    vecs[8]  = '{32'hFE112E23, 64'h40,        32'hFFFFFFFC, 32'h0,         64'hFFFFFFFFFFFFFFFC, 64'h0,                3'd2, 1'b0};
    vecs[9]  = '{32'h002081B3, 64'h44,        32'h0,        32'h0,         64'h0,                64'h0,                3'd0, 1'b0};
    vecs[10] = '{32'h03F0909B, 64'h48,        32'h1F,       32'h0,         64'h1F,               64'h0,                3'd6, 1'b0};
    vecs[11] = '{32'h00812083, 64'h4C,        32'h8,        32'h0,         64'h8,                64'h0,                3'd1, 1'b0};
    vecs[12] = '{32'hFFC08067, 64'h80,        32'hFFFFFFFC, 32'h0,         64'hFFFFFFFFFFFFFFFC, 64'h0,                3'd1, 1'b0};
    vecs[13] = '{32'hFE000EE3, 64'h0,         32'hFFFFFFFC, 32'hFFFFFFFC,  64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0; pc = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk_reset_outputs();

    // Streaming at full rate.
    for (int i = 0; i <= 5; i++) send(i);
    send(13);
    drain();

    // Backpressure: two accepts fill the buffer, third waits.
    out_ready = 1'b0;
    send(6);
    send(7);
    chk("full_ir32", 64'(b32.in_ready), 64'd0);
    chk("full_ir64", 64'(b64.in_ready), 64'd0);
    in_valid = 1'b1; instruction = vecs[8].inst; pc = vecs[8].pc;
    repeat (3) begin
      tick();
      chk("stall_ir32", 64'(b32.in_ready), 64'd0);
      chk("stall_ov64", 64'(b64.out_valid), 64'd1);
    end
    out_ready = 1'b1;
    send(8);
    drain();

    // Flush with both entries buffered and a word on the input.
    out_ready = 1'b0;
    send(9);
    send(10);
    in_valid = 1'b1; instruction = vecs[11].inst; pc = vecs[11].pc;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    q32.delete(); q64.delete();
    chk_idle("flush2");
    out_ready = 1'b1;
    repeat (4) tick();
    chk("flush2_quiet", 64'(b32.out_valid | b64.out_valid), 64'd0);

    // Flush beats a simultaneous pop and accept.
    send(9);
    in_valid = 1'b1; instruction = vecs[10].inst; pc = vecs[10].pc;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    q32.delete(); q64.delete();
    chk_idle("flush1");
    repeat (3) tick();

    send(11);
    send(12);
    drain();

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    send(0);
    send(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q32.delete(); q64.delete();
    chk_reset_outputs();

    out_ready = 1'b1;
    send(2);
    drain();
    repeat (3) tick();
    chk("end_q_empty", 64'(q32.size() + q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
